// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encodings and requester IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick2: 2-way one-hot picker; round-robin with a pointer register when
// ARB_ROUND_ROBIN_EN is defined, otherwise fixed load/store-first priority.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
`endif
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // Ties go to the pointer; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (valid[REQ_LS] && valid[REQ_IF]) begin
      gnt[ptr_q] = 1'b1;
    end else if (valid[REQ_LS]) begin
      gnt[REQ_LS] = 1'b1;
    end else if (valid[REQ_IF]) begin
      gnt[REQ_IF] = 1'b1;
    end else begin
      gnt = 2'b00;
    end
  end

  // After a grant the pointer moves to whichever side did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (take && (gnt != 2'b00)) begin
      ptr_d = gnt[REQ_IF] ? REQ_LS : REQ_IF;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_LS;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Load/store always beats fetch.
  always_comb begin
    gnt = 2'b00;
    if (valid[REQ_LS]) begin
      gnt[REQ_LS] = 1'b1;
    end else if (valid[REQ_IF]) begin
      gnt[REQ_IF] = 1'b1;
    end else begin
      gnt = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (req 0) and load/store (req 1),
// one transaction outstanding. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_valid,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_ready,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                m_valid,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                m_valid_q, m_valid_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                if_ready_q, if_ready_d;
  logic                ls_ready_q, ls_ready_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic [1:0]          gnt_s;
  logic                rsp_fire_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic pick_take_s;
  assign pick_take_s = (state_q == ARB_IDLE);
`endif

  arb_pick2 u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .rst   (rst),
    .take  (pick_take_s),
`endif
    .valid ({ls_valid, if_valid}),
    .gnt   (gnt_s)
  );

  // Transaction FSM: grant and capture command, hold it until accepted, await response.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_valid_d  = m_valid_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    if_ready_d = 1'b0;
    ls_ready_d = 1'b0;
    rsp_fire_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_s != 2'b00) begin
          owner_d   = gnt_s[REQ_LS];
          m_valid_d = 1'b1;
          state_d   = ARB_ISSUE;
          if (gnt_s[REQ_LS]) begin
            m_we_d     = ls_we;
            m_addr_d   = ls_addr;
            m_wdata_d  = ls_wdata;
            m_wstrb_d  = ls_wstrb;
            ls_ready_d = 1'b1;
          end else begin
            m_we_d     = 1'b0;
            m_addr_d   = if_addr;
            m_wdata_d  = {DATA_W{1'b0}};
            m_wstrb_d  = {STRB_W{1'b0}};
            if_ready_d = 1'b1;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_rvalid) begin
            rsp_fire_s = 1'b1;
            state_d    = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT;
          end
        end else begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_WAIT: begin
        if (m_rvalid) begin
          rsp_fire_s = 1'b1;
          state_d    = ARB_IDLE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = ARB_IDLE;
      end
    endcase
  end

  // Response routing to the owner; store completions return zero data.
  always_comb begin
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if (rsp_fire_s) begin
      if (owner_q == REQ_LS) begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = m_we_q ? {DATA_W{1'b0}} : m_rdata;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = m_rdata;
      end
    end else begin
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
    end
  end

  // State, command and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_IF;
      m_valid_q   <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= {ADDR_W{1'b0}};
      m_wdata_q   <= {DATA_W{1'b0}};
      m_wstrb_q   <= {STRB_W{1'b0}};
      if_ready_q  <= 1'b0;
      ls_ready_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      ls_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      m_valid_q   <= m_valid_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      if_ready_q  <= if_ready_d;
      ls_ready_q  <= ls_ready_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign ls_ready  = ls_ready_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign m_valid   = m_valid_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: reference model predicts grants, commands and
// responses; a memory agent and a response monitor compare against the queues.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_valid, ls_we, ls_ready, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wstrb;
  logic        m_valid, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {26'd0, 4'($urandom), 2'b00};
  endfunction

  // Reference model state
  logic [31:0] ref_mem [16];
  logic [31:0] dev_mem [16];
  cmd_t        cmd_q [$];
  logic [31:0] if_exp_q [$];
  logic [31:0] ls_exp_q [$];
  bit          idle_m = 1'b1;
  bit          ptr_m  = 1'b1;
  logic [31:0] last_if, last_ls;

  // Memory agent controls
  int  ready_lat = 0, rsp_lat = 1;
  bit  rand_lat = 1'b0;
  int  mstate = 0;

  // Monitor: at each edge predict the grant from the arbitration rules, then score responses.
  logic [1:0]  mon_exp_rdy;
  logic        mon_exp_ls;
  cmd_t        mon_cmd;
  initial begin
    last_if = 32'h0;
    last_ls = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cmd_q.delete(); if_exp_q.delete(); ls_exp_q.delete();
        idle_m = 1'b1; ptr_m = 1'b1; last_if = 32'h0; last_ls = 32'h0;
      end else begin
        mon_exp_rdy = 2'b00;
        mon_exp_ls  = 1'b0;
        if (idle_m && (if_valid || ls_valid)) begin
`ifdef ARB_ROUND_ROBIN_EN
          mon_exp_ls = (if_valid && ls_valid) ? ptr_m : ls_valid;
`else
          mon_exp_ls = ls_valid;
`endif
          mon_exp_rdy = mon_exp_ls ? 2'b10 : 2'b01;
        end
        if (mon_exp_rdy != 2'b00 || if_ready || ls_ready)
          check("grant", {ls_ready, if_ready}, mon_exp_rdy);
        if (mon_exp_rdy != 2'b00) begin
          ptr_m  = ~mon_exp_ls;
          idle_m = 1'b0;
          if (mon_exp_ls) begin
            mon_cmd = '{ls_we, ls_addr, ls_wdata, ls_wstrb};
            if (ls_we) begin
              ls_exp_q.push_back(32'h0);
              ref_mem[ls_addr[5:2]] = merge(ref_mem[ls_addr[5:2]], ls_wdata, ls_wstrb);
            end else begin
              ls_exp_q.push_back(ref_mem[ls_addr[5:2]]);
            end
          end else begin
            mon_cmd = '{1'b0, if_addr, 32'h0, 4'h0};
            if_exp_q.push_back(ref_mem[if_addr[5:2]]);
          end
          cmd_q.push_back(mon_cmd);
        end
        if (if_rvalid) begin
          idle_m = 1'b1;
          if (if_exp_q.size() == 0) check("if_rvalid_unexpected", if_rvalid, 1'b0);
          else last_if = if_exp_q.pop_front();
        end
        if (ls_rvalid) begin
          idle_m = 1'b1;
          if (ls_exp_q.size() == 0) check("ls_rvalid_unexpected", ls_rvalid, 1'b0);
          else last_ls = ls_exp_q.pop_front();
        end
        check("if_rdata", if_rdata, last_if);
        check("ls_rdata", ls_rdata, last_ls);
      end
    end
  end

  // Memory agent: checks the held command every cycle it is presented, then accepts and responds.
  int          wcnt = 0, rcnt = 0, cur_rl = 0, cur_sl = 0;
  bit          cmd_active = 1'b0;
  logic [31:0] mem_rd;
  initial begin
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (rst) cmd_active = 1'b0;
      if (mstate == 1) begin
        if (rcnt < cur_sl) rcnt++;
        else begin
          m_rvalid = 1'b1; m_rdata = mem_rd; mstate = 0;
        end
      end else if (m_valid && !rst) begin
        if (!cmd_active) begin
          cmd_active = 1'b1; wcnt = 0;
          cur_rl = rand_lat ? $urandom_range(0, 3) : ready_lat;
          cur_sl = rand_lat ? $urandom_range(0, 3) : rsp_lat;
        end
        if (cmd_q.size() == 0) check("m_valid_unexpected", m_valid, 1'b0);
        else check("m_cmd", {m_we, m_addr, m_wdata, m_wstrb}, cmd_q[0]);
        if (wcnt < cur_rl) wcnt++;
        else begin
          m_ready = 1'b1; cmd_active = 1'b0;
          mem_rd = m_we ? $urandom : dev_mem[m_addr[5:2]];
          if (m_we) dev_mem[m_addr[5:2]] = merge(dev_mem[m_addr[5:2]], m_wdata, m_wstrb);
          if (cmd_q.size() != 0) void'(cmd_q.pop_front());
          if (cur_sl == 0) begin
            m_rvalid = 1'b1; m_rdata = mem_rd;
          end else begin
            mstate = 1; rcnt = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; ls_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Counts edges from request to response, releasing each requester once accepted.
  bit first_mvalid;
  task automatic wait_rsp(input bit is_ls, output int n);
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) first_mvalid = m_valid;
      if (if_ready) if_valid = 1'b0;
      if (ls_ready) ls_valid = 1'b0;
    end while (!(is_ls ? ls_rvalid : if_rvalid) && n < 40);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(idle_m && mstate == 0 && cmd_q.size() == 0 && if_exp_q.size() == 0 &&
             ls_exp_q.size() == 0) && k < 60) begin
      tick(); k++;
    end
    check("drain", k < 60, 1'b1);
  endtask

  int n;
  bit seen;
  int dut_grants [$];
  int exp_order [4];

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; if_addr = 32'h0;
    ls_valid = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = {16'hA5C3, 12'h000, 4'(i)};
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEADBEEF;
    dev_mem[4] = 32'hDEADBEEF;
    #3;
    check("reset_outputs", {if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
                            m_valid, m_we, m_addr, m_wdata, m_wstrb}, 160'h0);
    do_reset();

    // Lone fetch of 0xDEADBEEF
    ready_lat = 0; rsp_lat = 1; rand_lat = 1'b0;
    if_valid = 1'b1; if_addr = 32'h10;
    wait_rsp(1'b0, n);
    check("fetch_mvalid_lat", first_mvalid, 1'b1);
    check("fetch_latency", n, 3);
    check("fetch_rdata", if_rdata, 32'hDEADBEEF);
    check("fetch_no_ls_rvalid", ls_rvalid, 1'b0);
    drain();

    // Contention: both requesters always pending
    do_reset();
    dut_grants.delete();
    if_valid = 1'b1; if_addr = rand_addr();
    ls_valid = 1'b1; ls_we = 1'b0; ls_addr = rand_addr();
    for (int c = 0; c < 40 && dut_grants.size() < 4; c++) begin
      tick();
      if (if_ready) begin dut_grants.push_back(0); if_addr = rand_addr(); end
      if (ls_ready) begin dut_grants.push_back(1); ls_addr = rand_addr(); end
    end
    if_valid = 1'b0; ls_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++)
      check("grant_order", (i < dut_grants.size()) ? dut_grants[i] : -1, exp_order[i]);
    drain();

    // Store held against a stalled memory
    ready_lat = 4; rsp_lat = 1;
    ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678; ls_wstrb = 4'h3;
    wait_rsp(1'b1, n);
    check("store_rsp_seen", ls_rvalid, 1'b1);
    check("store_rdata_zero", ls_rdata, 32'h0);
    drain();

    // Accept and respond in the same cycle
    ready_lat = 0; rsp_lat = 0;
    ls_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h14;
    wait_rsp(1'b1, n);
    check("same_cycle_latency", n, 2);
    drain();

    // Reset while waiting for the response
    ready_lat = 0; rsp_lat = 4;
    if_valid = 1'b1; if_addr = 32'h18;
    n = 0;
    do begin
      tick(); n++;
      if (if_ready) if_valid = 1'b0;
    end while (mstate != 1 && n < 20);
    rst = 1'b1;
    #1;
    check("rst_outputs_zero", {if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
                               m_valid, m_we, m_addr, m_wdata, m_wstrb}, 160'h0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | if_rvalid | ls_rvalid;
    end
    check("rst_lost_rsp", seen, 1'b0);
    rsp_lat = 1;
    ls_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h1C;
    wait_rsp(1'b1, n);
    check("post_rst_latency", n, 3);
    drain();

    // Randomized traffic with random memory latencies
    do_reset();
    rand_lat = 1'b1;
    for (int c = 0; c < 900; c++) begin
      tick();
      if (!if_valid || if_ready) begin
        if ($urandom_range(0, 9) < 6) begin if_valid = 1'b1; if_addr = rand_addr(); end
        else if_valid = 1'b0;
      end
      if (!ls_valid || ls_ready) begin
        if ($urandom_range(0, 9) < 6) begin
          ls_valid = 1'b1; ls_we = 1'($urandom); ls_addr = rand_addr();
          ls_wdata = $urandom; ls_wstrb = 4'($urandom);
        end else ls_valid = 1'b0;
      end
    end
    if_valid = 1'b0; ls_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
